// File: rtl/pll_lock_rst_gen.sv
// pll_lock_rst_gen: derives a clean active-low system reset from a PLL LOCKED flag.
//
// LOCKED is synchronised into the PLL output clock domain. It must then stay high for
// STABLE_CYCLES consecutive cycles before the system reset is released. When lock is
// lost while running, the reset is reasserted immediately. It is then held for at least
// RST_HOLD_CYCLES cycles before lock qualification starts again.
//
// Ports:
//   clk        - PLL output clock; every flop uses its rising edge
//   rst_n      - asynchronous active-low reset
//   locked     - PLL LOCKED status, asynchronous to clk
//   sys_rst_n  - registered active-low reset for logic clocked by clk
//   lock_ok    - registered, high only while running
//   lost_pulse - registered one-cycle pulse for each lock loss seen while running
//   lost_cnt   - registered count of lock losses, saturating at 255

module pll_lock_rst_gen #(
    parameter int unsigned STABLE_CYCLES   = 1024,  // legal 2..65535
    parameter int unsigned RST_HOLD_CYCLES = 16     // legal 1..65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       sys_rst_n,
    output logic       lock_ok,
    output logic       lost_pulse,
    output logic [7:0] lost_cnt
);

    localparam logic [15:0] StableLast = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HoldLast   = 16'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StRun      = 2'd2,
        StHold     = 2'd3
    } state_e;

    logic        sync1_q;
    logic        lock_s_q;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        lock_ok_q, lock_ok_d;
    logic        lost_pulse_q, lost_pulse_d;
    logic [7:0]  lost_cnt_q, lost_cnt_d;

    // Two-flop synchroniser; locked is read nowhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= locked;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lost_pulse_d = 1'b0;
        lost_cnt_d   = lost_cnt_q;

        unique case (state_q)
            StWaitLock: begin
                cnt_d = 16'd0;
                if (lock_s_q) begin
                    state_d = StStable;
                end
            end
            StStable: begin
                if (!lock_s_q) begin
                    // Any dropout restarts qualification from zero.
                    state_d = StWaitLock;
                    cnt_d   = 16'd0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                cnt_d = 16'd0;
                if (!lock_s_q) begin
                    state_d      = StHold;
                    lost_pulse_d = 1'b1;
                    if (lost_cnt_q != 8'hff) begin
                        lost_cnt_d = lost_cnt_q + 8'd1;
                    end
                end
            end
            StHold: begin
                // Hold time runs out regardless of lock state.
                if (cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = 16'd0;
            end
        endcase

        // Decoded from the next state so the outputs change on the same edge as the state.
        sys_rst_n_d = (state_d == StRun);
        lock_ok_d   = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StWaitLock;
            cnt_q        <= 16'd0;
            sys_rst_n_q  <= 1'b0;
            lock_ok_q    <= 1'b0;
            lost_pulse_q <= 1'b0;
            lost_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_rst_n_q  <= sys_rst_n_d;
            lock_ok_q    <= lock_ok_d;
            lost_pulse_q <= lost_pulse_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    assign sys_rst_n  = sys_rst_n_q;
    assign lock_ok    = lock_ok_q;
    assign lost_pulse = lost_pulse_q;
    assign lost_cnt   = lost_cnt_q;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Directed bench for pll_lock_rst_gen: one instance with STABLE_CYCLES=8 and
// RST_HOLD_CYCLES=4, plus one instance with default parameters for the long latency case.

module tb_pll_lock_rst_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       locked = 1'b0;
    logic       sys_rst_n;
    logic       lock_ok;
    logic       lost_pulse;
    logic [7:0] lost_cnt;

    logic       rst_n_def = 1'b1;
    logic       locked_def = 1'b0;
    logic       sys_rst_n_def;
    logic       lock_ok_def;
    logic       lost_pulse_def;
    logic [7:0] lost_cnt_def;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int p0;

    pll_lock_rst_gen #(
        .STABLE_CYCLES  (8),
        .RST_HOLD_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .sys_rst_n (sys_rst_n),
        .lock_ok   (lock_ok),
        .lost_pulse(lost_pulse),
        .lost_cnt  (lost_cnt)
    );

    pll_lock_rst_gen dut_def (
        .clk       (clk),
        .rst_n     (rst_n_def),
        .locked    (locked_def),
        .sys_rst_n (sys_rst_n_def),
        .lock_ok   (lock_ok_def),
        .lost_pulse(lost_pulse_def),
        .lost_cnt  (lost_cnt_def)
    );

    always #5 clk = ~clk;

    // Count lost_pulse cycles, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (lost_pulse === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sys_rst_n"}, 16'(sys_rst_n), 16'd0);
        chk({tag, "_lock_ok"}, 16'(lock_ok), 16'd0);
        chk({tag, "_lost_pulse"}, 16'(lost_pulse), 16'd0);
        chk({tag, "_lost_cnt"}, 16'(lost_cnt), 16'd0);
    endtask

    initial begin
        // Asynchronous reset with no clock edge in between.
        #1;
        rst_n     = 1'b0;
        rst_n_def = 1'b0;
        #1;
        chk_all_zero("reset");
        chk("reset_def_sys_rst_n", 16'(sys_rst_n_def), 16'd0);

        // Cold lock: release between edges, locked high before E0; rise on E10.
        tick();
        tick();
        rst_n  = 1'b1;
        locked = 1'b1;
        repeat (10) tick();
        chk("cold_e9_sys_rst_n", 16'(sys_rst_n), 16'd0);
        chk("cold_e9_lock_ok", 16'(lock_ok), 16'd0);
        tick();
        chk("cold_e10_sys_rst_n", 16'(sys_rst_n), 16'd1);
        chk("cold_e10_lock_ok", 16'(lock_ok), 16'd1);
        chk("cold_lost_cnt", 16'(lost_cnt), 16'd0);

        // Loss in RUN: low for edge F0 only; sys_rst_n falls on F2, back on F15.
        p0 = pulses;
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        chk("loss_f1_sys_rst_n", 16'(sys_rst_n), 16'd1);
        chk("loss_f1_lost_pulse", 16'(lost_pulse), 16'd0);
        tick();
        chk("loss_f2_sys_rst_n", 16'(sys_rst_n), 16'd0);
        chk("loss_f2_lock_ok", 16'(lock_ok), 16'd0);
        chk("loss_f2_lost_pulse", 16'(lost_pulse), 16'd1);
        chk("loss_f2_lost_cnt", 16'(lost_cnt), 16'd1);
        tick();
        chk("loss_f3_lost_pulse", 16'(lost_pulse), 16'd0);
        repeat (11) tick();
        chk("relock_f14_sys_rst_n", 16'(sys_rst_n), 16'd0);
        tick();
        chk("relock_f15_sys_rst_n", 16'(sys_rst_n), 16'd1);
        chk("relock_pulse_count", 16'(pulses - p0), 16'd1);
        chk("relock_lost_cnt", 16'(lost_cnt), 16'd1);

        // Glitch during STABLE: high for G0..G4, low at G5, high from G6; rise on G16.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_in_run");
        locked = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        p0 = pulses;
        locked = 1'b1;
        repeat (5) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        repeat (10) tick();
        chk("glitch_g15_sys_rst_n", 16'(sys_rst_n), 16'd0);
        tick();
        chk("glitch_g16_sys_rst_n", 16'(sys_rst_n), 16'd1);
        chk("glitch_pulse_count", 16'(pulses - p0), 16'd0);
        chk("glitch_lost_cnt", 16'(lost_cnt), 16'd0);

        // Async reset mid-HOLD, right on the lost_pulse cycle.
        locked = 1'b0;
        repeat (3) tick();
        chk("hold_f2_lost_pulse", 16'(lost_pulse), 16'd1);
        chk("hold_f2_lost_cnt", 16'(lost_cnt), 16'd1);
        #2;
        rst_n  = 1'b0;
        #1;
        chk_all_zero("rst_in_hold");
        locked = 1'b1;
        tick();
        #2;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("after_hold_e9_sys_rst_n", 16'(sys_rst_n), 16'd0);
        tick();
        chk("after_hold_e10_sys_rst_n", 16'(sys_rst_n), 16'd1);
        chk("after_hold_e10_lock_ok", 16'(lock_ok), 16'd1);
        chk("after_hold_lost_cnt", 16'(lost_cnt), 16'd0);

        // Saturation: 260 loss/relock rounds of 16 edges each.
        p0 = pulses;
        for (int i = 0; i < 260; i++) begin
            locked = 1'b0;
            tick();
            locked = 1'b1;
            repeat (15) tick();
            if (i == 253) chk("sat_254_lost_cnt", 16'(lost_cnt), 16'd254);
            if (i == 254) chk("sat_255_lost_cnt", 16'(lost_cnt), 16'd255);
        end
        chk("sat_final_lost_cnt", 16'(lost_cnt), 16'd255);
        chk("sat_pulse_count", 16'(pulses - p0), 16'd260);
        chk("sat_final_sys_rst_n", 16'(sys_rst_n), 16'd1);

        // Default parameters: rise exactly on E1026.
        rst_n_def  = 1'b1;
        locked_def = 1'b1;
        repeat (1026) tick();
        chk("def_e1025_sys_rst_n", 16'(sys_rst_n_def), 16'd0);
        tick();
        chk("def_e1026_sys_rst_n", 16'(sys_rst_n_def), 16'd1);
        chk("def_e1026_lock_ok", 16'(lock_ok_def), 16'd1);
        chk("def_lost_cnt", 16'(lost_cnt_def), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
